// File: rtl/rk_ps2_matrix_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rk_ps2_matrix_pkg
//  Description : Shared definitions for the PS/2 -> Radio-86RK key matrix
//                front end: set-2 prefix codes, receiver state encoding and
//                the scan-code -> matrix position lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package rk_ps2_matrix_pkg;

    localparam logic [7:0] c_code_e0 = 8'hE0;   // extended-key prefix
    localparam logic [7:0] c_code_f0 = 8'hF0;   // break (release) prefix
    localparam logic [7:0] c_code_e1 = 8'hE1;   // Pause sequence prefix

    // Modifier slots; L and R Shift are kept apart and ORed at the output.
    localparam logic [1:0] c_mod_lshift = 2'd0;
    localparam logic [1:0] c_mod_rshift = 2'd1;
    localparam logic [1:0] c_mod_ctrl   = 2'd2;
    localparam logic [1:0] c_mod_caps   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BITS   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // For modifiers, col[1:0] carries the modifier slot and row is unused.
    typedef struct packed {
        logic       valid;
        logic       is_mod;
        logic [2:0] row;
        logic [2:0] col;
    } key_map_t;

    // rc is written in octal: first digit row, second digit column.
    function automatic key_map_t key_at(input logic [5:0] rc);
        key_at = {2'b10, rc};
    endfunction

    function automatic key_map_t mod_at(input logic [1:0] slot);
        mod_at = {2'b11, 4'b0000, slot};
    endfunction

    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        case ({ext, code})
            9'h16C: m = key_at(6'o00);  9'h171: m = key_at(6'o01);  9'h076: m = key_at(6'o02);  9'h005: m = key_at(6'o03);
            9'h006: m = key_at(6'o04);  9'h004: m = key_at(6'o05);  9'h00C: m = key_at(6'o06);  9'h003: m = key_at(6'o07);
            9'h00D: m = key_at(6'o10);  9'h169: m = key_at(6'o11);  9'h05A: m = key_at(6'o12);  9'h066: m = key_at(6'o13);
            9'h16B: m = key_at(6'o14);  9'h175: m = key_at(6'o15);  9'h174: m = key_at(6'o16);  9'h172: m = key_at(6'o17);
            9'h045: m = key_at(6'o20);  9'h016: m = key_at(6'o21);  9'h01E: m = key_at(6'o22);  9'h026: m = key_at(6'o23);
            9'h025: m = key_at(6'o24);  9'h02E: m = key_at(6'o25);  9'h036: m = key_at(6'o26);  9'h03D: m = key_at(6'o27);
            9'h03E: m = key_at(6'o30);  9'h046: m = key_at(6'o31);  9'h052: m = key_at(6'o32);  9'h04C: m = key_at(6'o33);
            9'h041: m = key_at(6'o34);  9'h04E: m = key_at(6'o35);  9'h049: m = key_at(6'o36);  9'h04A: m = key_at(6'o37);
            9'h00E: m = key_at(6'o40);  9'h01C: m = key_at(6'o41);  9'h032: m = key_at(6'o42);  9'h021: m = key_at(6'o43);
            9'h023: m = key_at(6'o44);  9'h024: m = key_at(6'o45);  9'h02B: m = key_at(6'o46);  9'h034: m = key_at(6'o47);
            9'h033: m = key_at(6'o50);  9'h043: m = key_at(6'o51);  9'h03B: m = key_at(6'o52);  9'h042: m = key_at(6'o53);
            9'h04B: m = key_at(6'o54);  9'h03A: m = key_at(6'o55);  9'h031: m = key_at(6'o56);  9'h044: m = key_at(6'o57);
            9'h04D: m = key_at(6'o60);  9'h015: m = key_at(6'o61);  9'h02D: m = key_at(6'o62);  9'h01B: m = key_at(6'o63);
            9'h02C: m = key_at(6'o64);  9'h03C: m = key_at(6'o65);  9'h02A: m = key_at(6'o66);  9'h01D: m = key_at(6'o67);
            9'h022: m = key_at(6'o70);  9'h035: m = key_at(6'o71);  9'h01A: m = key_at(6'o72);  9'h054: m = key_at(6'o73);
            9'h05D: m = key_at(6'o74);  9'h05B: m = key_at(6'o75);  9'h055: m = key_at(6'o76);  9'h029: m = key_at(6'o77);
            9'h012: m = mod_at(c_mod_lshift);
            9'h059: m = mod_at(c_mod_rshift);
            9'h014: m = mod_at(c_mod_ctrl);
            9'h058: m = mod_at(c_mod_caps);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rk_ps2_matrix_if.sv
`default_nettype none
// ============================================================================
//  Module      : rk_ps2_matrix_if
//  Description : Bus between the PS/2 lines / PPA and the key matrix block.
//                ps2_clk, ps2_dat : PS/2 lines (input-only to the block)
//                addr[7:0]        : row select, bit r=1 selects row r
//                odata[7:0]       : column bits of the selected rows
//                shift[2:0]       : {RUS/LAT, US, SS}
//  Revision    : 1.0  initial release
// ============================================================================
interface rk_ps2_matrix_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] addr;
    logic [7:0] odata;
    logic [2:0] shift;

    modport master (output ps2_clk, ps2_dat, addr, input  odata, shift);
    modport slave  (input  ps2_clk, ps2_dat, addr, output odata, shift);
endinterface
`default_nettype wire

// File: rtl/rk_ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : rk_ps2_rx
//  Description : PS/2 device-to-host frame receiver. Synchronises both lines,
//                debounces ps2_clk, collects start/8 data/parity/stop and
//                emits a 1-clock code_vld with the received byte.
//  Ports       : clk, reset (sync, active-high), ps2_clk, ps2_dat (async in),
//                code[7:0], code_vld (1-clock strobe)
//  Revision    : 1.0  initial release
// ============================================================================
module rk_ps2_rx
    import rk_ps2_matrix_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_US = 200
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       ps2_clk,
    input  wire logic       ps2_dat,
    output logic [7:0]      code,
    output logic            code_vld
);
    localparam int c_timeout_cyc = TIMEOUT_US * (CLK_HZ / 1000000);
    localparam int c_tw          = $clog2(c_timeout_cyc + 1);
    localparam int c_fw          = $clog2(FILT_LEN + 1);

    logic [1:0]      r_clk_sync;
    logic [1:0]      r_dat_sync;
    logic            r_clk_filt;
    logic [c_fw-1:0] r_filt_cnt;
    rx_state_t       r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shreg;
    logic            r_par;
    logic [c_tw-1:0] r_tmr;

    logic w_settle;
    logic w_fall;

    // The filtered clock only follows the synchronised line after it has
    // differed for FILT_LEN consecutive samples.
    assign w_settle = (r_clk_sync[1] != r_clk_filt) &&
                      (r_filt_cnt == c_fw'(FILT_LEN - 1));
    assign w_fall   = w_settle && r_clk_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (w_settle) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par    <= 1'b0;
            r_tmr    <= '0;
            code     <= '0;
            code_vld <= 1'b0;
        end else begin
            code_vld <= 1'b0;
            if (w_fall || r_state == ST_IDLE) begin
                r_tmr <= '0;
            end else if (r_tmr == c_tw'(c_timeout_cyc - 1)) begin
                // Device went quiet mid-frame: drop what was collected.
                r_tmr   <= '0;
                r_state <= ST_IDLE;
            end else begin
                r_tmr <= r_tmr + 1'b1;
            end

            if (w_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_sync[1]) begin
                            r_state  <= ST_BITS;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_BITS: begin
                        r_shreg  <= {r_dat_sync[1], r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        r_par   <= r_dat_sync[1];
                        r_state <= ST_STOP;
                    end
                    default: begin
                        // Odd parity over data+parity and a high stop bit.
                        if (r_dat_sync[1] && (^{r_shreg, r_par})) begin
                            code     <= r_shreg;
                            code_vld <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rk_ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : rk_ps2_matrix
//  Description : PS/2 keyboard to Radio-86RK 8x8 key matrix plus modifiers.
//                Decodes set-2 make/break codes into the matrix and returns
//                the ORed column bits of all rows selected by bus.addr.
//  Ports       : clk, reset (sync, active-high),
//                bus (slave): ps2_clk, ps2_dat, addr in; odata, shift out
//  Revision    : 1.0  initial release
// ============================================================================
module rk_ps2_matrix
    import rk_ps2_matrix_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_US = 200
) (
    input  wire logic       clk,
    input  wire logic       reset,
    rk_ps2_matrix_if.slave  bus
);
    logic [7:0]      w_code;
    logic            w_code_vld;
    key_map_t        w_hit;
    logic            w_is_prefix;
    logic [3:0]      w_mods_nx;
    logic [7:0]      w_odata_nx;

    logic            r_ext;
    logic            r_brk;
    logic [7:0][7:0] r_mat;
    logic [3:0]      r_mods;
    logic [7:0]      r_odata;
    logic [2:0]      r_shift;

    rk_ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .FILT_LEN   (FILT_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_dat  (bus.ps2_dat),
        .code     (w_code),
        .code_vld (w_code_vld)
    );

    assign w_hit       = map_key(r_ext, w_code);
    assign w_is_prefix = (w_code == c_code_e0) || (w_code == c_code_f0) ||
                         (w_code == c_code_e1);

    // Next modifier state is formed here so shift can register it directly,
    // giving one clock from code_vld to the output.
    always_comb begin
        w_mods_nx = r_mods;
        if (w_code_vld && !w_is_prefix && w_hit.valid && w_hit.is_mod) begin
            w_mods_nx[w_hit.col[1:0]] = ~r_brk;
        end
    end

    always_comb begin
        w_odata_nx = '0;
        for (int r = 0; r < 8; r++) begin
            if (bus.addr[r]) begin
                w_odata_nx = w_odata_nx | r_mat[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext   <= 1'b0;
            r_brk   <= 1'b0;
            r_mat   <= '0;
            r_mods  <= '0;
            r_odata <= '0;
            r_shift <= '0;
        end else begin
            if (w_code_vld) begin
                if (w_code == c_code_e0) begin
                    r_ext <= 1'b1;
                end else if (w_code == c_code_f0) begin
                    r_brk <= 1'b1;
                end else if (w_code != c_code_e1) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_hit.valid && !w_hit.is_mod) begin
                        r_mat[w_hit.row][w_hit.col] <= ~r_brk;
                    end
                end
            end
            r_mods  <= w_mods_nx;
            r_shift <= {w_mods_nx[c_mod_caps], w_mods_nx[c_mod_ctrl],
                        w_mods_nx[c_mod_lshift] | w_mods_nx[c_mod_rshift]};
            r_odata <= w_odata_nx;
        end
    end

    assign bus.odata = r_odata;
    assign bus.shift = r_shift;
endmodule
`default_nettype wire

// File: tb/tb_rk_ps2_matrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rk_ps2_matrix
//  Description : Self-checking bench for rk_ps2_matrix: directed scenarios
//                with literal expectations plus randomized key traffic
//                compared every cycle against a behavioural keyboard model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rk_ps2_matrix;
    import rk_ps2_matrix_pkg::*;

    localparam int HALF = 20;   // system clocks per PS/2 clock half-period

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rk_ps2_matrix_if bus();

    rk_ps2_matrix #(
        .CLK_HZ     (10000000),
        .FILT_LEN   (8),
        .TIMEOUT_US (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Key layout, index = row*8 + col, value = {ext, set-2 code}.
    logic [8:0] keytab [64] = '{
        9'h16C, 9'h171, 9'h076, 9'h005, 9'h006, 9'h004, 9'h00C, 9'h003,
        9'h00D, 9'h169, 9'h05A, 9'h066, 9'h16B, 9'h175, 9'h174, 9'h172,
        9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
        9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A,
        9'h00E, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034,
        9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044,
        9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D,
        9'h022, 9'h035, 9'h01A, 9'h054, 9'h05D, 9'h05B, 9'h055, 9'h029
    };
    logic [7:0] modcodes [4] = '{8'h12, 8'h59, 8'h14, 8'h58};

    // Behavioural keyboard state.
    bit m_mat [8][8];
    bit m_ls, m_rs, m_ctrl, m_caps, m_ext, m_brk;

    function automatic logic [7:0] exp_od(input logic [7:0] a);
        logic [7:0] v = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (a[r] && m_mat[r][c]) v[c] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] exp_sh();
        return {m_caps, m_ctrl, m_ls | m_rs};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_mat[r][c] = 1'b0;
        {m_ls, m_rs, m_ctrl, m_caps, m_ext, m_brk} = '0;
    endtask

    task automatic model_code(input logic [7:0] c);
        int hit = -1;
        if (c == 8'hE0) m_ext = 1'b1;
        else if (c == 8'hF0) m_brk = 1'b1;
        else if (c != 8'hE1) begin
            for (int i = 0; i < 64; i++)
                if (keytab[i] == {m_ext, c}) hit = i;
            if (hit >= 0) m_mat[hit / 8][hit % 8] = !m_brk;
            else if (!m_ext) begin
                if (c == 8'h12) m_ls = !m_brk;
                if (c == 8'h59) m_rs = !m_brk;
                if (c == 8'h14) m_ctrl = !m_brk;
                if (c == 8'h58) m_caps = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input bit b, input bit glitch);
        bus.ps2_dat = b;
        if (glitch) begin
            wait_cyc(5);
            bus.ps2_clk = 1'b0;
            wait_cyc(3);
            bus.ps2_clk = 1'b1;
            wait_cyc(HALF - 8);
        end else begin
            wait_cyc(HALF);
        end
        bus.ps2_clk = 1'b0;
        wait_cyc(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    // bad=1 flips the parity bit; glitch_at selects a bit whose high phase
    // carries a short clock pulse (-1 for none).
    task automatic send_frame(input logic [7:0] c, input bit bad, input int glitch_at);
        bit b;
        chk_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 0) b = 1'b0;
            else if (i <= 8) b = c[i-1];
            else if (i == 9) b = (~^c) ^ bad;
            else b = 1'b1;
            ps2_bit(b, i == glitch_at);
        end
        wait_cyc(HALF);
        if (!bad) model_code(c);
        chk_en = 1'b1;
    endtask

    task automatic send(input logic [7:0] c);
        send_frame(c, 1'b0, -1);
    endtask

    // New addr must show on odata after exactly one clock.
    task automatic set_addr(input logic [7:0] a);
        chk_en = 1'b0;
        bus.addr = a;
        wait_cyc(1);
        chk("addr_latency", bus.odata, exp_od(a));
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (bus.odata !== exp_od(bus.addr) || bus.shift !== exp_sh()) begin
                failures++;
                $display("FAIL cycle_cmp t=%0t addr=%h odata=%h exp=%h shift=%b exp=%b",
                         $time, bus.addr, bus.odata, exp_od(bus.addr), bus.shift, exp_sh());
            end
        end
    end

    initial begin
        key_map_t km;
        logic [7:0] c;
        int sel;
        int idx;

        bus.ps2_clk = 1'b1;
        bus.ps2_dat = 1'b1;
        bus.addr    = 8'hFF;
        model_reset();
        wait_cyc(4);
        chk("rst_odata", bus.odata, 8'h00);
        chk("rst_shift", {5'b0, bus.shift}, 8'h00);
        reset = 1'b0;
        wait_cyc(2);
        chk_en = 1'b1;

        // Shared lookup agrees with the bench's own layout.
        for (int i = 0; i < 64; i++) begin
            km = map_key(keytab[i][8], keytab[i][7:0]);
            chk("map_table", km, {2'b10, i[5:0]});
        end

        // 1: A press/release.
        send(8'h1C);
        set_addr(8'h10);
        chk("t1_a_make", bus.odata, 8'h02);
        send(8'hF0); send(8'h1C);
        chk("t1_a_break", bus.odata, 8'h00);

        // 2: Space and row select patterns.
        send(8'h29);
        set_addr(8'h80); chk("t2_row7", bus.odata, 8'h80);
        set_addr(8'hFF); chk("t2_all", bus.odata, 8'h80);
        set_addr(8'h00); chk("t2_none", bus.odata, 8'h00);
        send(8'hF0); send(8'h29);

        // 3: both shifts share SS.
        send(8'h12); send(8'h59);
        chk("t3_both", {5'b0, bus.shift}, 8'h01);
        send(8'hF0); send(8'h12);
        chk("t3_r_held", {5'b0, bus.shift}, 8'h01);
        send(8'hF0); send(8'h59);
        chk("t3_none", {5'b0, bus.shift}, 8'h00);

        // 4: extended Up (row1 col5), then unmapped plain 75.
        send(8'hE0); send(8'h75);
        set_addr(8'h02);
        chk("t4_up", bus.odata, 8'h20);
        send(8'h75);
        chk("t4_kp8", bus.odata, 8'h20);

        // 5: bad parity dropped; partial frame aborted by timeout.
        set_addr(8'h10);
        send_frame(8'h1C, 1'b1, -1);
        chk("t5_badpar", bus.odata, 8'h00);
        chk_en = 1'b0;
        ps2_bit(1'b0, 1'b0); ps2_bit(1'b0, 1'b0); ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
        bus.ps2_dat = 1'b1;
        wait_cyc(300);
        chk_en = 1'b1;
        send(8'h1C);
        chk("t5_after_to", bus.odata, 8'h02);

        // 6: clock glitch ignored; reset mid-frame.
        send(8'hF0); send(8'h1C);
        send_frame(8'h1C, 1'b0, 3);
        chk("t6_glitch", bus.odata, 8'h02);
        send(8'h12);
        chk_en = 1'b0;
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
        reset = 1'b1;
        wait_cyc(1);
        chk("t6_rst_odata", bus.odata, 8'h00);
        chk("t6_rst_shift", {5'b0, bus.shift}, 8'h00);
        wait_cyc(1);
        reset = 1'b0;
        bus.ps2_dat = 1'b1;
        model_reset();
        wait_cyc(4);
        chk_en = 1'b1;
        send(8'h1C);
        chk("t6_post_rst", bus.odata, 8'h02);

        // Randomized traffic against the model.
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                idx = $urandom_range(0, 63);
                if (keytab[idx][8]) send(8'hE0);
                if ($urandom_range(0, 1) == 1) send(8'hF0);
                send(keytab[idx][7:0]);
            end else if (sel <= 6) begin
                if ($urandom_range(0, 1) == 1) send(8'hF0);
                send(modcodes[$urandom_range(0, 3)]);
            end else if (sel == 7) begin
                c = 8'($urandom_range(0, 255));
                send(c);
            end else if (sel == 8) begin
                idx = $urandom_range(0, 63);
                send_frame(keytab[idx][7:0], 1'b1, -1);
            end else begin
                send(8'hE1);
                send(8'hE0);
                c = 8'($urandom_range(0, 255));
                send(c);
            end
            set_addr(8'($urandom_range(0, 255)));
            wait_cyc(3);
        end

        chk_en = 1'b0;
        wait_cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
